// File: rtl/matrix_operand_loader.sv
// Serial loader for the 4x4 complex matrix multiplier: collects A then B over a valid/ready
// stream, presents both as packed buses, pulses Start and tracks completion/error/timeout.
module matrix_operand_loader #(
  parameter int W            = 8,
  parameter int N            = 4,
  parameter int START_CYCLES = 2,
  parameter int TIMEOUT      = 255
) (
  input  logic             CLK,
  input  logic             MasterReset,
  input  logic             Enable,
  input  logic             Clear,
  input  logic             InValid,
  output logic             InReady,
  input  logic [W-1:0]     InReal,
  input  logic [W-1:0]     InImag,
  output logic [N*N*W-1:0] AReal,
  output logic [N*N*W-1:0] AImag,
  output logic [N*N*W-1:0] BReal,
  output logic [N*N*W-1:0] BImag,
  output logic             Start,
  input  logic             Listo,
  input  logic             MultError,
  output logic             Busy,
  output logic             Done,
  output logic             ErrFlag
);

  localparam int NN = N * N;
  localparam int CW = $clog2(2 * NN);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(START_CYCLES + 1);

  typedef enum logic [1:0] {LOAD, STRT, WAIT, ERR} stateT;

  stateT         state, stateNext;
  logic [CW-1:0] count;
  logic [TW-1:0] toCnt;
  logic [SW-1:0] startCnt;
  logic [W-1:0]  elemRe [2*NN];
  logic [W-1:0]  elemIm [2*NN];
  logic          transfer, lastElem, startDone, timedOut;

  // Elements 0..NN-1 form A and NN..2NN-1 form B, so the stream count indexes storage directly
  assign InReady   = MasterReset && Enable && (state == LOAD);
  assign transfer  = InValid && InReady && !Clear;
  assign lastElem  = (count == CW'(2 * NN - 1));
  assign startDone = (startCnt == SW'(START_CYCLES - 1));
  assign timedOut  = (toCnt == TW'(TIMEOUT - 1));

  assign Start = (state == STRT);
  assign Busy  = (state == STRT) || (state == WAIT);
  assign Done  = Enable && !Clear && (state == WAIT) && Listo;

  always_ff @(posedge CLK or negedge MasterReset) begin
    if (!MasterReset) state <= LOAD;
    else              state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (Enable) begin
      if (Clear) begin
        stateNext = LOAD;
      end else begin
        case (state)
          LOAD: if (transfer && lastElem) stateNext = STRT;
          STRT: if (startDone) stateNext = WAIT;
          WAIT: begin
            if (Listo)                      stateNext = LOAD;
            else if (MultError || timedOut) stateNext = ERR;
          end
          default: stateNext = state;
        endcase
      end
    end
  end

  // Counters only advance on enabled cycles; leaving a state rewinds its counter
  always_ff @(posedge CLK or negedge MasterReset) begin
    if (!MasterReset) begin
      count    <= '0;
      toCnt    <= '0;
      startCnt <= '0;
      ErrFlag  <= 1'b0;
    end else if (Enable) begin
      if (Clear) begin
        count    <= '0;
        toCnt    <= '0;
        startCnt <= '0;
        ErrFlag  <= 1'b0;
      end else begin
        if (transfer) count <= lastElem ? '0 : count + CW'(1);
        startCnt <= (state == STRT && !startDone) ? startCnt + SW'(1) : '0;
        toCnt    <= (state == WAIT && stateNext == WAIT) ? toCnt + TW'(1) : '0;
        if (state == WAIT && stateNext == ERR) ErrFlag <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge MasterReset) begin
    if (!MasterReset) begin
      for (int i = 0; i < 2 * NN; i++) begin
        elemRe[i] <= '0;
        elemIm[i] <= '0;
      end
    end else if (transfer) begin
      elemRe[count] <= InReal;
      elemIm[count] <= InImag;
    end
  end

  for (genvar i = 0; i < NN; i++) begin : gPack
    assign AReal[i*W +: W] = elemRe[i];
    assign AImag[i*W +: W] = elemIm[i];
    assign BReal[i*W +: W] = elemRe[NN + i];
    assign BImag[i*W +: W] = elemIm[NN + i];
  end

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Directed/randomized bench for matrix_operand_loader; expected matrices come from a simple
// element-order model, handshake timing from the documented cycle behaviour.
module tb_matrix_operand_loader;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int NN = N * N;
  localparam int BW = NN * W;

  logic          CLK = 1'b0;
  logic          MasterReset, Enable, Clear, InValid, Listo, MultError;
  logic [W-1:0]  InReal, InImag;
  logic          InReady, Start, Busy, Done, ErrFlag;
  logic [BW-1:0] AReal, AImag, BReal, BImag;

  int            errors = 0;
  int            checks = 0;
  int            mCount;
  logic [BW-1:0] expAre, expAim, expBre, expBim;
  int            n;

  always #5 CLK = ~CLK;

  matrix_operand_loader dut (
    .CLK(CLK), .MasterReset(MasterReset), .Enable(Enable), .Clear(Clear),
    .InValid(InValid), .InReady(InReady), .InReal(InReal), .InImag(InImag),
    .AReal(AReal), .AImag(AImag), .BReal(BReal), .BImag(BImag),
    .Start(Start), .Listo(Listo), .MultError(MultError),
    .Busy(Busy), .Done(Done), .ErrFlag(ErrFlag)
  );

  task automatic checkOutput(input string tag, input logic [BW-1:0] observed,
                             input logic [BW-1:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  task automatic modelReset();
    mCount = 0;
    expAre = '0; expAim = '0; expBre = '0; expBim = '0;
  endtask

  // A accepted element k lands in A(k) for k<16, otherwise in B(k-16)
  task automatic modelAccept(input logic [W-1:0] re, input logic [W-1:0] im);
    if (mCount < NN) begin
      expAre[mCount*W +: W] = re;
      expAim[mCount*W +: W] = im;
    end else begin
      expBre[(mCount-NN)*W +: W] = re;
      expBim[(mCount-NN)*W +: W] = im;
    end
    mCount = (mCount + 1) % (2 * NN);
  endtask

  task automatic applyStimulus(input logic [W-1:0] re, input logic [W-1:0] im, input int maxGap);
    int gaps;
    gaps = (maxGap > 0) ? int'($urandom_range(maxGap, 0)) : 0;
    repeat (gaps) begin
      InValid = 1'b0;
      InReal  = W'($urandom);
      InImag  = W'($urandom);
      @(negedge CLK);
    end
    InValid = 1'b1;
    InReal  = re;
    InImag  = im;
    @(negedge CLK);
    InValid = 1'b0;
    modelAccept(re, im);
  endtask

  task automatic checkBuses(input string tag);
    checkOutput({tag, "_AReal"}, AReal, expAre);
    checkOutput({tag, "_AImag"}, AImag, expAim);
    checkOutput({tag, "_BReal"}, BReal, expBre);
    checkOutput({tag, "_BImag"}, BImag, expBim);
  endtask

  // pattern 0: all 1+1i; 1: A(k)=k, B(k)=(16+k)-ki; 2: random
  task automatic loadMatrices(input int pattern, input int maxGap);
    logic [W-1:0] re, im;
    for (int k = 0; k < 2 * NN; k++) begin
      if (pattern == 0) begin
        re = 8'd1; im = 8'd1;
      end else if (pattern == 1) begin
        if (k < NN) begin
          re = W'(k); im = '0;
        end else begin
          re = W'(k); im = W'(-(k - NN));
        end
      end else begin
        re = W'($urandom); im = W'($urandom);
      end
      if (k == 2 * NN - 1) checkOutput("no_early_start", Start, 1'b0);
      applyStimulus(re, im, maxGap);
    end
  endtask

  task automatic measureStart(input int stall, output int cnt);
    cnt = 0;
    checkOutput("start_latency", Start, 1'b1);
    checkOutput("busy_in_strt", Busy, 1'b1);
    checkOutput("inready_in_strt", InReady, 1'b0);
    for (int i = 0; i < 40 && Start === 1'b1; i++) begin
      cnt++;
      if (i == 0 && stall > 0) Enable = 1'b0;
      if (i == stall && stall > 0) Enable = 1'b1;
      @(negedge CLK);
    end
    Enable = 1'b1;
  endtask

  initial begin
    MasterReset = 1'b0; Enable = 1'b1; Clear = 1'b0; InValid = 1'b0;
    InReal = '0; InImag = '0; Listo = 1'b0; MultError = 1'b0;
    modelReset();
    #12;
    checkOutput("rst_inready", InReady, 1'b0);
    checkOutput("rst_start", Start, 1'b0);
    checkOutput("rst_busy", Busy, 1'b0);
    checkOutput("rst_errflag", ErrFlag, 1'b0);
    checkBuses("rst");
    @(negedge CLK);
    MasterReset = 1'b1;
    @(negedge CLK);
    checkOutput("inready_after_rst", InReady, 1'b1);

    $display("[TB] back-to-back 1+1i load");
    loadMatrices(0, 0);
    measureStart(0, n);
    checkOutput("t1_start_len", n, 2);
    checkOutput("t1_busy_wait", Busy, 1'b1);
    checkOutput("t1_lanes", AReal, {NN{8'h01}});
    checkBuses("t1");

    // Listo ten cycles after Start; InValid in WAIT must be ignored
    InValid = 1'b1; InReal = 8'hEE; InImag = 8'hEE;
    repeat (8) begin
      checkOutput("done_idle", Done, 1'b0);
      @(negedge CLK);
    end
    InValid = 1'b0; Listo = 1'b1;
    #1 checkOutput("t3_done", Done, 1'b1);
    @(negedge CLK);
    Listo = 1'b0;
    #1 checkOutput("t3_done_end", Done, 1'b0);
    checkOutput("t3_inready", InReady, 1'b1);
    checkOutput("t3_errflag", ErrFlag, 1'b0);
    checkOutput("t3_busy", Busy, 1'b0);

    $display("[TB] indexed pattern with gaps");
    loadMatrices(1, 3);
    measureStart(0, n);
    checkOutput("t2_start_len", n, 2);
    checkBuses("t2");
    checkOutput("t2_bimag5", BImag[5*W +: W], 8'hFB);
    checkOutput("t2_areal9", AReal[9*W +: W], 8'd9);
    Listo = 1'b1;
    @(negedge CLK);
    Listo = 1'b0;

    $display("[TB] multiplier error and clear");
    loadMatrices(2, 2);
    measureStart(0, n);
    repeat (3) @(negedge CLK);
    MultError = 1'b1;
    @(negedge CLK);
    MultError = 1'b0;
    checkOutput("t4_errflag", ErrFlag, 1'b1);
    checkOutput("t4_inready", InReady, 1'b0);
    checkOutput("t4_busy", Busy, 1'b0);
    repeat (4) @(negedge CLK);
    Listo = 1'b1;
    #1 checkOutput("t4_done_in_err", Done, 1'b0);
    @(negedge CLK);
    Listo = 1'b0;
    checkOutput("t4_errflag_sticky", ErrFlag, 1'b1);
    Clear = 1'b1;
    @(negedge CLK);
    Clear = 1'b0;
    mCount = 0;
    checkOutput("t4_errflag_clr", ErrFlag, 1'b0);
    checkOutput("t4_inready_clr", InReady, 1'b1);
    checkBuses("t4_kept");
    loadMatrices(2, 1);
    measureStart(0, n);
    Listo = 1'b1; MultError = 1'b1;
    #1 checkOutput("t4_both_done", Done, 1'b1);
    @(negedge CLK);
    Listo = 1'b0; MultError = 1'b0;
    checkOutput("t4_both_errflag", ErrFlag, 1'b0);
    checkOutput("t4_both_inready", InReady, 1'b1);
    checkBuses("t4");

    $display("[TB] timeout");
    loadMatrices(2, 0);
    measureStart(0, n);
    repeat (254) @(negedge CLK);
    checkOutput("t5_not_yet", ErrFlag, 1'b0);
    checkOutput("t5_busy", Busy, 1'b1);
    @(negedge CLK);
    checkOutput("t5_timeout", ErrFlag, 1'b1);
    checkOutput("t5_busy_err", Busy, 1'b0);
    Clear = 1'b1;
    @(negedge CLK);
    Clear = 1'b0;
    mCount = 0;

    $display("[TB] partial load, clear, stall, reset");
    for (int k = 0; k < 10; k++) applyStimulus(W'($urandom), W'($urandom), 1);
    InValid = 1'b1; InReal = 8'h55; InImag = 8'h55; Clear = 1'b1;
    @(negedge CLK);
    Clear = 1'b0; InValid = 1'b0;
    mCount = 0;
    checkOutput("t6_start_after_clear", Start, 1'b0);
    loadMatrices(2, 1);
    measureStart(5, n);
    checkOutput("t6_stretched_start", n, 7);
    checkBuses("t6");
    repeat (3) @(negedge CLK);
    MasterReset = 1'b0;
    modelReset();
    #1;
    checkBuses("t6_rst");
    checkOutput("t6_rst_busy", Busy, 1'b0);
    checkOutput("t6_rst_inready", InReady, 1'b0);
    @(negedge CLK);
    MasterReset = 1'b1;
    @(negedge CLK);
    checkOutput("t6_inready_release", InReady, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
